regression_trainer: RTL and testbench
=====================================

# regression_trainer

Streaming least-squares fitter: the training counterpart of `regression_lineaire`. It accepts (taille, prix) samples over a valid/ready stream and accumulates the running sums. When a batch ends, it computes slope and intercept in signed Q8.8 with one shared sequential divider, then presents them on a valid/ready result port for loading into the predictor.

## Interface
- `MAX_SAMPLES`, 255: batch cap. The sample counter is 8 bits, so the maximum legal value is 255.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `taille`  in  8  sample x, unsigned.
- `prix`  in  8  sample y, unsigned.
- `s_valid`  in  1  sample present.
- `s_last`  in  1  final sample of the batch; qualified by `s_valid`.
- `s_ready`  out  1  block can accept a sample.
- `slope`  out  16  signed Q8.8 slope, saturated.
- `intercept`  out  16  signed Q8.8 intercept, saturated.
- `fit_degenerate`  out  1  denominator was 0 (fewer than 2 distinct x values).
- `fit_sat`  out  1  slope or intercept was clamped.
- `fit_trunc`  out  1  batch was closed by the `MAX_SAMPLES` cap, not by `s_last`.
- `fit_valid`  out  1  result valid.
- `fit_ready`  in  1  consumer takes the result.

## Operation
- **States:** ACCUM → PREP_A → DIV_A → PREP_B → DIV_B → OUT.
  - OUT waits for `fit_ready`, then returns to ACCUM.
- **Accept rule:** a sample is accepted on an edge where `s_valid && s_ready`.
  - `s_ready` = 1 only in ACCUM.
  - Each accepted sample updates:
    - n (8 b)
    - Sx, Sy (16 b)
    - Sxy, Sxx (24 b)
- **End of batch:** an accepted sample with `s_last = 1`, or the accepted sample that brings n to `MAX_SAMPLES`, moves the FSM to PREP_A.
  - The cap case sets `fit_trunc`.
  - The sums include the closing sample.
- **PREP_A:**
  - num = n·Sxy − Sx·Sy (33 b signed)
  - den = n·Sxx − Sx² (33 b, ≥ 0)
  - den = 0 sets `fit_degenerate`.
- **DIV_A:** shared restoring magnitude divider, 41 iterations, one quotient bit per cycle.
  - a_q = (num << 8) / den, truncated toward zero.
  - In the degenerate case the divider still runs 41 cycles and a_q is forced to 0.
- **PREP_B:**
  - a_q is clamped to 18-bit signed for internal use.
  - bnum = Sy·256 − a_q·Sx (35 b signed).
- **DIV_B:** 35 iterations, b_q = bnum / n, truncated toward zero.
- **OUT (output register load):**
  - `slope` = a_q saturated to [−32768, 32767].
  - `intercept` = b_q saturated to the same range.
  - `fit_sat` is set if either saturated.
  - The intercept always uses the 18-bit-clamped a_q, not the 16-bit output value.
- **Result hold:** outputs hold stable while `fit_valid = 1 && fit_ready = 0`.
  - On the handshake edge all sums, n and flags clear, and the FSM enters ACCUM.
  - `slope`/`intercept` keep their last values until the next OUT load.
- **Input rules:**
  - `s_last` is ignored when `s_valid = 0`.
  - Samples presented while `s_ready = 0` are not consumed. The source must hold them.

## Timing
- **Reset:** all outputs 0 except `s_ready` = 1. The FSM is in ACCUM with sums cleared.
  - `rst` mid-batch or mid-division discards all work. No partial result is ever emitted.
- **Latency:** `fit_valid` rises on the 79th rising edge after the edge that accepted the closing sample:
  - PREP_A 1 cycle
  - DIV_A 41 cycles
  - PREP_B 1 cycle
  - DIV_B 35 cycles
  - OUT load 1 cycle
- **Degenerate and saturated cases:** same latency.
- **Throughput:** one sample per cycle in ACCUM.
- **Reacceptance:** the first sample of the next batch can be accepted on the cycle after the `fit_ready` handshake.
- `fit_valid` is registered and drops on the edge after the handshake.

## Configuration
- Macro: `REGRESSION_TRAINER_ROUND_EN`.
- **Defined:** both divisions round to nearest, with ties away from zero. Before each division, |divisor|/2 is added to |dividend|.
- **Undefined:** both divisions truncate toward zero.
- Latency is identical in both builds.
- All test values below are exact, so they hold with or without the macro.

## Test plan
1. **Reset:** hold `rst` 2 cycles → `s_ready` = 1; `fit_valid`, `slope`, `intercept` and all flags = 0.
2. **Positive slope:** (1,2), (2,4), (3,6 + `s_last`) back-to-back → after exactly 79 cycles:
   - `slope` = 0x0200, `intercept` = 0x0000
   - `fit_degenerate` = `fit_sat` = `fit_trunc` = 0
3. **Negative slope with stall:** (10,50), (20,40), (30,30 + `s_last`), with `fit_ready` held low 5 cycles:
   - `slope` = 0xFF00, `intercept` = 0x3C00
   - values stable during the stall; `s_ready` = 0 until the handshake
4. **Degenerate x:** (5,7), (5,9 + `s_last`) → `fit_degenerate` = 1, `slope` = 0x0000, `intercept` = 0x0800.
   - Single-sample variant: (3,100 + `s_last`) → `intercept` = 0x6400, `fit_degenerate` = 1.
5. **Saturation:** (0,0), (1,255 + `s_last`) → `slope` = 0x7FFF, `fit_sat` = 1, `intercept` = 0x0000.
6. **Cap, then reset mid-operation:**
   - 255 samples of (x=i, y=i) with `s_last` never asserted → `fit_trunc` = 1, `slope` = 0x0100, `intercept` = 0x0000.
   - Repeat and assert `rst` at cycle 20 of DIV_A → `fit_valid` never rises, `s_ready` = 1 the cycle after `rst` releases, and a fresh batch fits correctly.

Source files
------------

// File: rtl/regression_trainer_if.sv
// rtl/regression_trainer_if.sv - sample stream and fit result signals of regression_trainer
interface regression_trainer_if;
    logic [7:0]  taille;
    logic [7:0]  prix;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [15:0] slope;
    logic [15:0] intercept;
    logic        fit_degenerate;
    logic        fit_sat;
    logic        fit_trunc;
    logic        fit_valid;
    logic        fit_ready;

    modport master (
        output taille, prix, s_valid, s_last, fit_ready,
        input  s_ready, slope, intercept, fit_degenerate, fit_sat, fit_trunc, fit_valid
    );

    modport slave (
        input  taille, prix, s_valid, s_last, fit_ready,
        output s_ready, slope, intercept, fit_degenerate, fit_sat, fit_trunc, fit_valid
    );
endinterface

// File: rtl/regression_trainer.sv
// rtl/regression_trainer.sv - streaming least-squares fitter, Q8.8 slope/intercept; optional REGRESSION_TRAINER_ROUND_EN
module regression_trainer #(
    parameter int MAX_SAMPLES = 255
) (
    input logic                 clk,
    input logic                 rst,
    regression_trainer_if.slave bus
);
    typedef enum logic [2:0] {ACCUM, PREP_A, DIV_A, PREP_B, DIV_B, OUT} state_t;

    localparam logic [7:0] CAP_M1 = 8'(MAX_SAMPLES - 1);

    state_t             state_q, state_d;
    logic [7:0]         n_q, n_d;
    logic [15:0]        sx_q, sx_d, sy_q, sy_d;
    logic [23:0]        sxy_q, sxy_d, sxx_q, sxx_d;
    logic               trunc_q, trunc_d, degen_q, degen_d, neg_q, neg_d;
    logic [32:0]        div_q, div_d, rem_q, rem_d;
    logic [40:0]        dq_q, dq_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [17:0]        a18_q, a18_d;
    logic [15:0]        slope_q, slope_d, intercept_q, intercept_d;
    logic               fdeg_q, fdeg_d, fsat_q, fsat_d, ftrunc_q, ftrunc_d, fvalid_q, fvalid_d;

    // Clamp a sign/magnitude quotient into an 18-bit two's complement value.
    function automatic logic [17:0] sat18(input logic [40:0] m, input logic ng);
        if (ng) return (m > 41'd131072) ? 18'h20000 : 18'(~m[17:0] + 18'd1);
        else    return (m > 41'd131071) ? 18'h1FFFF : m[17:0];
    endfunction

    // Clamp a sign/magnitude quotient into the 16-bit Q8.8 output range.
    function automatic logic [15:0] sat16(input logic [40:0] m, input logic ng);
        if (ng) return (m > 41'd32768) ? 16'h8000 : 16'(~m[15:0] + 16'd1);
        else    return (m > 41'd32767) ? 16'h7FFF : m[15:0];
    endfunction

    // Fit numerator/denominator from the running sums.
    logic [31:0] nxy, sxsy, nxx, sxsx;
    logic [32:0] num, den, num_mag;
    logic [40:0] dividend_a, round_a;
    assign nxy     = {24'b0, n_q} * {8'b0, sxy_q};
    assign sxsy    = {16'b0, sx_q} * {16'b0, sy_q};
    assign nxx     = {24'b0, n_q} * {8'b0, sxx_q};
    assign sxsx    = {16'b0, sx_q} * {16'b0, sx_q};
    assign num     = {1'b0, nxy} - {1'b0, sxsy};
    assign den     = {1'b0, nxx} - {1'b0, sxsx};
    assign num_mag = num[32] ? -num : num;

    // Intercept numerator uses the 18-bit clamped slope, zero when degenerate.
    logic [17:0] a18_v;
    logic [34:0] prod_b, bnum, bnum_mag, dividend_b, round_b;
    assign a18_v    = degen_q ? 18'd0 : sat18(dq_q, neg_q);
    assign prod_b   = {{17{a18_v[17]}}, a18_v} * {19'b0, sx_q};
    assign bnum     = {11'b0, sy_q, 8'b0} - prod_b;
    assign bnum_mag = bnum[34] ? -bnum : bnum;

`ifdef REGRESSION_TRAINER_ROUND_EN
    assign round_a = {9'b0, den[32:1]};
    assign round_b = {28'b0, n_q[7:1]};
`else
    assign round_a = 41'd0;
    assign round_b = 35'd0;
`endif
    assign dividend_a = {num_mag, 8'b0} + round_a;
    assign dividend_b = bnum_mag + round_b;

    // One restoring step: shift dividend MSB into the remainder, subtract if it fits.
    logic [33:0] rem_sh, sub;
    logic        qbit;
    logic [32:0] rem_next;
    logic [40:0] dq_step;
    assign rem_sh   = {rem_q, dq_q[40]};
    assign sub      = rem_sh - {1'b0, div_q};
    assign qbit     = ~sub[33];
    assign rem_next = qbit ? sub[32:0] : rem_sh[32:0];
    assign dq_step  = {dq_q[39:0], qbit};

    // Output saturation detection.
    logic [17:0] a_mag18;
    logic        a_sat, b_sat;
    assign a_mag18 = a18_q[17] ? -a18_q : a18_q;
    assign a_sat   = a18_q[17] ? (a_mag18 > 18'd32768) : (a_mag18 > 18'd32767);
    assign b_sat   = neg_q ? (dq_q[34:0] > 35'd32768) : (dq_q[34:0] > 35'd32767);

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;  n_d = n_q;  sx_d = sx_q;  sy_d = sy_q;
        sxy_d = sxy_q;  sxx_d = sxx_q;  trunc_d = trunc_q;  degen_d = degen_q;
        neg_d = neg_q;  div_d = div_q;  rem_d = rem_q;  dq_d = dq_q;  cnt_d = cnt_q;
        a18_d = a18_q;  slope_d = slope_q;  intercept_d = intercept_q;
        fdeg_d = fdeg_q;  fsat_d = fsat_q;  ftrunc_d = ftrunc_q;  fvalid_d = fvalid_q;
        case (state_q)
            ACCUM: if (bus.s_valid) begin
                n_d   = n_q + 8'd1;
                sx_d  = sx_q + {8'b0, bus.taille};
                sy_d  = sy_q + {8'b0, bus.prix};
                sxy_d = sxy_q + {8'b0, {8'b0, bus.taille} * {8'b0, bus.prix}};
                sxx_d = sxx_q + {8'b0, {8'b0, bus.taille} * {8'b0, bus.taille}};
                if (bus.s_last || n_q == CAP_M1) begin
                    state_d = PREP_A;
                    trunc_d = !bus.s_last;
                end
            end
            PREP_A: begin
                degen_d = (den == 33'd0);
                neg_d   = num[32];
                div_d   = den;
                rem_d   = 33'd0;
                dq_d    = dividend_a;
                cnt_d   = 6'd0;
                state_d = DIV_A;
            end
            DIV_A: begin
                rem_d = rem_next;
                dq_d  = dq_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd40) state_d = PREP_B;
            end
            PREP_B: begin
                a18_d   = a18_v;
                neg_d   = bnum[34];
                div_d   = {25'b0, n_q};
                rem_d   = 33'd0;
                dq_d    = {dividend_b, 6'b0};
                cnt_d   = 6'd0;
                state_d = DIV_B;
            end
            DIV_B: begin
                rem_d = rem_next;
                dq_d  = dq_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd34) state_d = OUT;
            end
            OUT: if (!fvalid_q) begin
                slope_d     = sat16({23'b0, a_mag18}, a18_q[17]);
                intercept_d = sat16({6'b0, dq_q[34:0]}, neg_q);
                fsat_d      = a_sat || b_sat;
                fdeg_d      = degen_q;
                ftrunc_d    = trunc_q;
                fvalid_d    = 1'b1;
            end else if (bus.fit_ready) begin
                fvalid_d = 1'b0;  fdeg_d = 1'b0;  fsat_d = 1'b0;  ftrunc_d = 1'b0;
                n_d = 8'd0;  sx_d = 16'd0;  sy_d = 16'd0;  sxy_d = 24'd0;  sxx_d = 24'd0;
                trunc_d = 1'b0;  degen_d = 1'b0;
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;  n_q <= '0;  sx_q <= '0;  sy_q <= '0;  sxy_q <= '0;  sxx_q <= '0;
            trunc_q <= 1'b0;  degen_q <= 1'b0;  neg_q <= 1'b0;  div_q <= '0;  rem_q <= '0;
            dq_q <= '0;  cnt_q <= '0;  a18_q <= '0;  slope_q <= '0;  intercept_q <= '0;
            fdeg_q <= 1'b0;  fsat_q <= 1'b0;  ftrunc_q <= 1'b0;  fvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;  n_q <= n_d;  sx_q <= sx_d;  sy_q <= sy_d;  sxy_q <= sxy_d;
            sxx_q <= sxx_d;  trunc_q <= trunc_d;  degen_q <= degen_d;  neg_q <= neg_d;
            div_q <= div_d;  rem_q <= rem_d;  dq_q <= dq_d;  cnt_q <= cnt_d;  a18_q <= a18_d;
            slope_q <= slope_d;  intercept_q <= intercept_d;  fdeg_q <= fdeg_d;
            fsat_q <= fsat_d;  ftrunc_q <= ftrunc_d;  fvalid_q <= fvalid_d;
        end
    end

    assign bus.s_ready        = (state_q == ACCUM);
    assign bus.slope          = slope_q;
    assign bus.intercept      = intercept_q;
    assign bus.fit_degenerate = fdeg_q;
    assign bus.fit_sat        = fsat_q;
    assign bus.fit_trunc      = ftrunc_q;
    assign bus.fit_valid      = fvalid_q;
endmodule

// File: tb/tb_regression_trainer.sv
// tb/tb_regression_trainer.sv - directed self-checking bench for regression_trainer
module tb_regression_trainer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc;

    regression_trainer_if bus();
    regression_trainer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic send_one(input logic [7:0] x, input logic [7:0] y, input logic last);
        bus.taille = x;  bus.prix = y;  bus.s_valid = 1'b1;  bus.s_last = last;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;  bus.s_last = 1'b0;
    endtask

    task automatic wait_fit(output int c);
        c = 0;
        while (bus.fit_valid !== 1'b1 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic handshake();
        bus.fit_ready = 1'b1;
        @(posedge clk); #1;
        bus.fit_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready got %b exp 1", bus.s_ready); end
        tests++; if (bus.fit_valid !== 1'b0) begin fails++; $display("FAIL reset_fit_valid got %b exp 0", bus.fit_valid); end
        tests++; if ({bus.slope, bus.intercept} !== 32'h0) begin fails++; $display("FAIL reset_outputs got %h exp 0", {bus.slope, bus.intercept}); end
        tests++; if ({bus.fit_degenerate, bus.fit_sat, bus.fit_trunc} !== 3'b000) begin fails++;
            $display("FAIL reset_flags got %b exp 000", {bus.fit_degenerate, bus.fit_sat, bus.fit_trunc}); end
    endtask

    task automatic test_pos_slope(input string tag);
        send_one(8'd1, 8'd2, 1'b0);  send_one(8'd2, 8'd4, 1'b0);  send_one(8'd3, 8'd6, 1'b1);
        wait_fit(cyc);
        tests++; if (cyc !== 79) begin fails++; $display("FAIL %s_latency got %0d exp 79", tag, cyc); end
        tests++; if (bus.slope !== 16'h0200) begin fails++; $display("FAIL %s_slope got %h exp 0200", tag, bus.slope); end
        tests++; if (bus.intercept !== 16'h0000) begin fails++; $display("FAIL %s_intercept got %h exp 0000", tag, bus.intercept); end
        tests++; if ({bus.fit_degenerate, bus.fit_sat, bus.fit_trunc} !== 3'b000) begin fails++;
            $display("FAIL %s_flags got %b exp 000", tag, {bus.fit_degenerate, bus.fit_sat, bus.fit_trunc}); end
        handshake();
        tests++; if ({bus.fit_valid, bus.s_ready} !== 2'b01) begin fails++;
            $display("FAIL %s_after_hs got valid,ready=%b exp 01", tag, {bus.fit_valid, bus.s_ready}); end
    endtask

    task automatic test_neg_slope_stall();
        send_one(8'd10, 8'd50, 1'b0);  send_one(8'd20, 8'd40, 1'b0);  send_one(8'd30, 8'd30, 1'b1);
        wait_fit(cyc);
        tests++; if (cyc !== 79) begin fails++; $display("FAIL neg_latency got %0d exp 79", cyc); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if ({bus.slope, bus.intercept} !== 32'hFF00_3C00) begin fails++;
                $display("FAIL neg_stall_values cycle %0d got %h exp ff003c00", i, {bus.slope, bus.intercept}); end
            tests++; if ({bus.fit_valid, bus.s_ready} !== 2'b10) begin fails++;
                $display("FAIL neg_stall_handshake cycle %0d got valid,ready=%b exp 10", i, {bus.fit_valid, bus.s_ready}); end
        end
        handshake();
        tests++; if ({bus.fit_valid, bus.s_ready} !== 2'b01) begin fails++;
            $display("FAIL neg_after_hs got valid,ready=%b exp 01", {bus.fit_valid, bus.s_ready}); end
        tests++; if (bus.slope !== 16'hFF00) begin fails++; $display("FAIL neg_slope_hold got %h exp ff00", bus.slope); end
    endtask

    task automatic test_degenerate();
        send_one(8'd5, 8'd7, 1'b0);  send_one(8'd5, 8'd9, 1'b1);
        wait_fit(cyc);
        tests++; if (cyc !== 79) begin fails++; $display("FAIL degen_latency got %0d exp 79", cyc); end
        tests++; if ({bus.slope, bus.intercept} !== 32'h0000_0800) begin fails++;
            $display("FAIL degen_values got %h exp 00000800", {bus.slope, bus.intercept}); end
        tests++; if ({bus.fit_degenerate, bus.fit_sat, bus.fit_trunc} !== 3'b100) begin fails++;
            $display("FAIL degen_flags got %b exp 100", {bus.fit_degenerate, bus.fit_sat, bus.fit_trunc}); end
        handshake();
        send_one(8'd3, 8'd100, 1'b1);
        wait_fit(cyc);
        tests++; if (cyc !== 79) begin fails++; $display("FAIL single_latency got %0d exp 79", cyc); end
        tests++; if ({bus.slope, bus.intercept} !== 32'h0000_6400) begin fails++;
            $display("FAIL single_values got %h exp 00006400", {bus.slope, bus.intercept}); end
        tests++; if (bus.fit_degenerate !== 1'b1) begin fails++; $display("FAIL single_degenerate got %b exp 1", bus.fit_degenerate); end
        handshake();
    endtask

    task automatic test_saturation();
        send_one(8'd0, 8'd0, 1'b0);  send_one(8'd1, 8'd255, 1'b1);
        wait_fit(cyc);
        tests++; if (cyc !== 79) begin fails++; $display("FAIL sat_latency got %0d exp 79", cyc); end
        tests++; if ({bus.slope, bus.intercept} !== 32'h7FFF_0000) begin fails++;
            $display("FAIL sat_values got %h exp 7fff0000", {bus.slope, bus.intercept}); end
        tests++; if ({bus.fit_degenerate, bus.fit_sat, bus.fit_trunc} !== 3'b010) begin fails++;
            $display("FAIL sat_flags got %b exp 010", {bus.fit_degenerate, bus.fit_sat, bus.fit_trunc}); end
        handshake();
    endtask

    task automatic test_cap();
        for (int i = 0; i < 255; i++) send_one(8'(i), 8'(i), 1'b0);
        tests++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL cap_closes got s_ready=%b exp 0", bus.s_ready); end
        wait_fit(cyc);
        tests++; if (cyc !== 79) begin fails++; $display("FAIL cap_latency got %0d exp 79", cyc); end
        tests++; if ({bus.slope, bus.intercept} !== 32'h0100_0000) begin fails++;
            $display("FAIL cap_values got %h exp 01000000", {bus.slope, bus.intercept}); end
        tests++; if ({bus.fit_degenerate, bus.fit_sat, bus.fit_trunc} !== 3'b001) begin fails++;
            $display("FAIL cap_flags got %b exp 001", {bus.fit_degenerate, bus.fit_sat, bus.fit_trunc}); end
        handshake();
    endtask

    task automatic test_reset_mid_div();
        int seen;
        for (int i = 0; i < 255; i++) send_one(8'(i), 8'(i), 1'b0);
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_s_ready got %b exp 1", bus.s_ready); end
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (bus.fit_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_mid_no_result got %0d valid cycles exp 0", seen); end
        test_pos_slope("fresh");
    endtask

    initial begin
        bus.taille = '0;  bus.prix = '0;  bus.s_valid = 1'b0;  bus.s_last = 1'b0;  bus.fit_ready = 1'b0;
        test_reset();
        test_pos_slope("pos");
        test_neg_slope_stall();
        test_degenerate();
        test_saturation();
        test_cap();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
